// File: rtl/fp_pkg.sv
// Shared FP unit definitions: format widths, converter constants, FSM encoding,
// instruction codes and the rounder interface structs.
package fp_pkg;

   localparam int FP_BIAS      = 127;
   localparam int FP_EXP_W     = 8;
   localparam int FP_MAN_W     = 23;
   localparam int CVT_EXP_INIT = 158;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } cvt_state_t;

   // 5-bit i_inst codes of the FP execute unit
   localparam logic [4:0] OP_FADD      = 5'h00;
   localparam logic [4:0] OP_FSUB      = 5'h01;
   localparam logic [4:0] OP_FMUL      = 5'h02;
   localparam logic [4:0] OP_FCVT_W_S  = 5'h05;
   localparam logic [4:0] OP_FCVT_WU_S = 5'h06;
   localparam logic [4:0] OP_FCVT_S_W  = 5'h07;
   localparam logic [4:0] OP_FCVT_S_WU = 5'h08;

   // Normalized magnitude: hidden bit already stripped, bits [30:8] are the mantissa
   typedef struct packed {
      logic [FP_EXP_W-1:0] exp;
      logic [30:0]         mag;
   } rnd_in_t;

   typedef struct packed {
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W-1:0] mant;
      logic                inexact;
   } rnd_out_t;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even of a normalized 31-bit magnitude to a
// 23-bit mantissa; a mantissa carry-out bumps the exponent.
module fp_rne_round
   import fp_pkg::*;
(
   input  rnd_in_t  i_rnd,
   output rnd_out_t o_rnd
);

   logic [FP_MAN_W-1:0] mant;
   logic                lsb, guard, sticky, rup;
   logic [FP_MAN_W:0]   sum;

   assign mant   = i_rnd.mag[30:8];
   assign lsb    = i_rnd.mag[8];
   assign guard  = i_rnd.mag[7];
   assign sticky = |i_rnd.mag[6:0];
   assign rup    = guard & (sticky | lsb);
   assign sum    = {1'b0, mant} + {{FP_MAN_W{1'b0}}, rup};

   // On carry-out the low bits wrap to zero, which is exactly the required mantissa
   assign o_rnd.mant    = sum[FP_MAN_W-1:0];
   assign o_rnd.exp     = i_rnd.exp + {{(FP_EXP_W-1){1'b0}}, sum[FP_MAN_W]};
   assign o_rnd.inexact = guard | sticky;

endmodule

// File: rtl/fp_cvt_sw.sv
// FCVT.S.W / FCVT.S.WU: iterative int32 -> single converter with RNE rounding.
// Valid/ready request side, one-cycle o_valid pulse with held result.
module fp_cvt_sw
   import fp_pkg::*;
#(
   parameter int EXP_INIT     = CVT_EXP_INIT,
   parameter int COARSE_SHIFT = 8
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic        i_unsigned,
   input  logic [31:0] i_data,
   output logic        o_ready,
   output logic        o_valid,
   output logic [31:0] o_fp,
   output logic        o_inexact
);

   localparam logic [FP_EXP_W-1:0] EXP_INIT_L = EXP_INIT[FP_EXP_W-1:0];
   localparam logic [FP_EXP_W-1:0] COARSE_L   = COARSE_SHIFT[FP_EXP_W-1:0];

   cvt_state_t          state_q, state_d;
   logic                sign_q, sign_d;
   logic [31:0]         mag_q, mag_d;
   logic [FP_EXP_W-1:0] exp_q, exp_d;
   logic [31:0]         fp_q, fp_d;
   logic                inx_q, inx_d;

   logic                acc_sign;
   logic [31:0]         acc_mag;
   rnd_in_t             rnd_in;
   rnd_out_t            rnd_out;

   // Signed 0x80000000 negates to itself, which is the right unsigned magnitude
   assign acc_sign = ~i_unsigned & i_data[31];
   assign acc_mag  = acc_sign ? (32'd0 - i_data) : i_data;

   assign rnd_in.exp = exp_q;
   assign rnd_in.mag = mag_q[30:0];

   fp_rne_round u_round (
      .i_rnd (rnd_in),
      .o_rnd (rnd_out)
   );

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      fp_d    = fp_q;
      inx_d   = inx_q;
      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               sign_d = acc_sign;
               mag_d  = acc_mag;
               exp_d  = EXP_INIT_L;
               if (acc_mag == 32'd0) begin
                  fp_d    = 32'd0;
                  inx_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (mag_q[31]) begin
               state_d = ROUND;
            end else if (mag_q[31 -: COARSE_SHIFT] == '0) begin
               mag_d = mag_q << COARSE_SHIFT;
               exp_d = exp_q - COARSE_L;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 1'b1;
            end
         end
         ROUND: begin
            fp_d    = {sign_q, rnd_out.exp, rnd_out.mant};
            inx_d   = rnd_out.inexact;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         mag_q   <= 32'd0;
         exp_q   <= '0;
         fp_q    <= 32'd0;
         inx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         fp_q    <= fp_d;
         inx_q   <= inx_d;
      end
   end

   assign o_ready   = (state_q == IDLE);
   assign o_valid   = (state_q == DONE);
   assign o_fp      = fp_q;
   assign o_inexact = inx_q;

endmodule
